// File: rtl/memory_writer_pkg.sv
// Shared types and constants for the byte-stream to SB_RAM40_4K write-port packer.
package memory_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_WRITE,
    ST_FINISH
  } state_t;

  // SB_RAM40_4K MASK: a 1 bit protects that bit from being written.
  localparam logic [15:0] MASK_FULL       = 16'h0000;
  localparam logic [15:0] MASK_LOW_ONLY   = 16'hFF00;
  localparam int          RAM_WADDR_WIDTH = 11;

endpackage

// File: rtl/memory_writer.sv
// Packs a valid/ready byte stream into 16-bit words (even byte -> [7:0], odd byte -> [15:8])
// and writes them to consecutive SB_RAM40_4K word addresses starting at a latched base.
module memory_writer
  import memory_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic [LEN_WIDTH-1:0]       length,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  output logic                       busy,
  output logic                       done,
  output logic [RAM_WADDR_WIDTH-1:0] w_addr,
  output logic [15:0]                w_data,
  output logic                       write_en,
  output logic                       w_clk_en,
  output logic [15:0]                mask
);

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [7:0]            low_byte;
  logic                  accept;
  logic                  last_byte;

  assign w_clk_en  = 1'b1;
  assign accept    = byte_valid && byte_ready;
  assign last_byte = (remaining == LEN_WIDTH'(1));

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (start) next_state = (length == '0) ? ST_FINISH : ST_LOW;
      ST_LOW:    if (accept) next_state = last_byte ? ST_WRITE : ST_HIGH;
      ST_HIGH:   if (accept) next_state = ST_WRITE;
      ST_WRITE:  next_state = (remaining != '0) ? ST_LOW : ST_FINISH;
      ST_FINISH: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Control outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      remaining  <= '0;
      low_byte   <= '0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      write_en   <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      mask       <= '0;
    end else begin
      byte_ready <= (next_state == ST_LOW) || (next_state == ST_HIGH);
      busy       <= (next_state != ST_IDLE);
      done       <= (next_state == ST_FINISH);
      write_en   <= (next_state == ST_WRITE);

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            ptr       <= base_addr;
            remaining <= length;
          end
        end
        ST_LOW: begin
          if (accept) begin
            low_byte  <= byte_in;
            remaining <= remaining - LEN_WIDTH'(1);
            if (last_byte) begin
              // Odd tail: only the low lane is written, the upper byte in RAM is preserved.
              w_addr <= {{(RAM_WADDR_WIDTH - ADDR_WIDTH){1'b0}}, ptr};
              w_data <= {8'h00, byte_in};
              mask   <= MASK_LOW_ONLY;
            end
          end
        end
        ST_HIGH: begin
          if (accept) begin
            remaining <= remaining - LEN_WIDTH'(1);
            w_addr    <= {{(RAM_WADDR_WIDTH - ADDR_WIDTH){1'b0}}, ptr};
            w_data    <= {byte_in, low_byte};
            mask      <= MASK_FULL;
          end
        end
        ST_WRITE:  ptr <= ptr + ADDR_WIDTH'(1);
        ST_FINISH: ;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_writer.sv
// Randomized bench for memory_writer: expected RAM writes are derived from the byte stream
// (pairs into words at base+k) and a masked RAM image is compared against observed writes.
module tb_memory_writer;

  localparam int AW = 8;
  localparam int LW = 9;

  typedef struct {
    logic [10:0] addr;
    logic [15:0] data;
    logic [15:0] mask;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          busy;
  logic          done;
  logic [10:0]   w_addr;
  logic [15:0]   w_data;
  logic          write_en;
  logic          w_clk_en;
  logic [15:0]   mask;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int ready_viol = 0;
  wr_t obs_q[$];
  logic [15:0] ref_ram[256];
  logic [15:0] dut_ram[256];
  logic [7:0]  tx_bytes[512];

  memory_writer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy),
    .done(done), .w_addr(w_addr), .w_data(w_data), .write_en(write_en),
    .w_clk_en(w_clk_en), .mask(mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Observe the RAM write port and apply writes to a masked RAM image.
  always @(negedge clk) begin
    if (!reset) begin
      if (write_en) begin
        obs_q.push_back('{w_addr, w_data, mask});
        dut_ram[w_addr[7:0]] = (dut_ram[w_addr[7:0]] & mask) | (w_data & ~mask);
        if (byte_ready) ready_viol++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_transfer(input logic [7:0] base, input int len, input int gap, input bit inject);
    wr_t exp_q[$];
    wr_t e;
    int  done_before, viol_before, idx, cycles, mism;
    bit  acc, pending;
    for (int k = 0; 2 * k < len; k++) begin
      e.addr = 11'((int'(base) + k) % 256);
      if (2 * k + 1 < len) begin
        e.data = {tx_bytes[2*k+1], tx_bytes[2*k]};
        e.mask = 16'h0000;
      end else begin
        e.data = {8'h00, tx_bytes[2*k]};
        e.mask = 16'hFF00;
      end
      exp_q.push_back(e);
    end
    obs_q.delete();
    done_before = done_cnt;
    viol_before = ready_viol;

    @(negedge clk);
    start = 1'b1; base_addr = base; length = LW'(len);
    @(posedge clk);
    idx = 0; cycles = 0; pending = 1'b0;
    while (idx < len && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (pending) begin
        check("wr_latency", {31'd0, write_en}, 1);
        pending = 1'b0;
      end
      start      = inject && ($urandom_range(0, 3) == 0);
      base_addr  = AW'($urandom);
      length     = LW'($urandom);
      byte_valid = ($urandom_range(0, 99) >= gap);
      byte_in    = tx_bytes[idx];
      acc        = byte_valid && byte_ready;
      @(posedge clk);
      if (acc) begin
        idx++;
        if (idx % 2 == 0 || idx == len) pending = 1'b1;
      end
    end
    if (idx < len) check("byte_timeout", idx, len);

    @(negedge clk);
    start = 1'b0; byte_valid = 1'b0;
    if (len == 0) begin
      check("done_after_start", {31'd0, done}, 1);
      check("no_write_len0", {31'd0, write_en}, 0);
    end else begin
      check("last_write", {31'd0, write_en}, 1);
      @(negedge clk);
      check("done_latency", {31'd0, done}, 1);
    end
    repeat (2) @(negedge clk);
    check("busy_idle", {31'd0, busy}, 0);
    check("done_count", done_cnt - done_before, 1);
    check("write_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check("w_addr", {21'd0, obs_q[i].addr}, {21'd0, exp_q[i].addr});
      check("mask", {16'd0, obs_q[i].mask}, {16'd0, exp_q[i].mask});
      check("w_data", {16'd0, obs_q[i].data & ~exp_q[i].mask}, {16'd0, exp_q[i].data & ~exp_q[i].mask});
    end
    foreach (exp_q[i])
      ref_ram[exp_q[i].addr[7:0]] = (ref_ram[exp_q[i].addr[7:0]] & exp_q[i].mask) |
                                    (exp_q[i].data & ~exp_q[i].mask);
    mism = 0;
    for (int a = 0; a < 256; a++) if (ref_ram[a] !== dut_ram[a]) mism++;
    check("ram_image", mism, 0);
    check("ready_in_write", ready_viol - viol_before, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, {31'd0, byte_ready}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_write_en"}, {31'd0, write_en}, 0);
    check({tag, "_w_addr"}, {21'd0, w_addr}, 0);
    check({tag, "_w_data"}, {16'd0, w_data}, 0);
    check({tag, "_mask"}, {16'd0, mask}, 0);
  endtask

  initial begin
    int done_before;
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; byte_in = '0; byte_valid = 1'b0;
    for (int a = 0; a < 256; a++) begin
      ref_ram[a] = 16'($urandom);
      dut_ram[a] = ref_ram[a];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("w_clk_en", {31'd0, w_clk_en}, 1);
    reset = 1'b0;

    tx_bytes[0] = 8'hA1; tx_bytes[1] = 8'hB2; tx_bytes[2] = 8'hC3; tx_bytes[3] = 8'hD4;
    run_transfer(8'h10, 4, 0, 1'b0);
    check("readback_lo", {24'd0, dut_ram[8'h10][7:0]}, 32'hA1);
    check("readback_hi", {24'd0, dut_ram[8'h10][15:8]}, 32'hB2);

    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33;
    run_transfer(8'h20, 3, 0, 1'b0);

    for (int i = 0; i < 4; i++) tx_bytes[i] = 8'($urandom);
    run_transfer(8'hFF, 4, 30, 1'b1);

    run_transfer(8'h55, 0, 0, 1'b0);

    for (int i = 0; i < 6; i++) tx_bytes[i] = 8'($urandom);
    run_transfer(8'($urandom), 6, 50, 1'b1);

    // Abort after one of four bytes.
    done_before = done_cnt;
    obs_q.delete();
    @(negedge clk);
    start = 1'b1; base_addr = 8'h40; length = LW'(4);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b1; byte_in = 8'h99;
    @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    check("abort_writes", obs_q.size(), 0);
    check("abort_done", done_cnt - done_before, 0);

    for (int t = 0; t < 8; t++) begin
      int len;
      len = (t == 7) ? $urandom_range(200, 511) : $urandom_range(0, 21);
      for (int i = 0; i < len; i++) tx_bytes[i] = 8'($urandom);
      run_transfer(8'($urandom), len, $urandom_range(0, 60), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
